// File: rtl/lsu_pkg.sv
// Shared encodings, widths and FSM states for the load/store controller.
// Illegal-access detection is only meaningful when LSU_MISALIGN_TRAP_EN is defined.
// No logic of its own.
package lsu_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LD_RD,
        LD_CAP,
        ST_WR,
        RMW_RD,
        RMW_MERGE,
        RMW_WR
`ifdef LSU_MISALIGN_TRAP_EN
        , ERR
`endif
    } state_t;

    // True when the access cannot be issued without trapping.
    function automatic logic access_illegal(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'b00);
            SZ_RSVD: bad = 1'b1;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane extraction (sign/zero extend) for loads and lane merge for sub-word stores.
// Purely combinational, zero latency.
// No flow control; follows its inputs every cycle.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [15:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rd_word[7:0];
        case (lane)
            2'b00: byte_sel = rd_word[7:0];
            2'b01: byte_sel = rd_word[15:8];
            2'b10: byte_sel = rd_word[23:16];
            2'b11: byte_sel = rd_word[31:24];
            default: byte_sel = rd_word[7:0];
        endcase
        half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
    end

    always_comb begin
        ld_data = rd_word;
        case (size)
            SZ_BYTE: ld_data = {{24{~uns & byte_sel[7]}}, byte_sel};
            SZ_HALF: ld_data = {{16{~uns & half_sel[15]}}, half_sel};
            default: ld_data = rd_word;
        endcase
    end

    always_comb begin
        merge_data = rd_word;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    2'b00: merge_data[7:0]   = wdata[7:0];
                    2'b01: merge_data[15:8]  = wdata[7:0];
                    2'b10: merge_data[23:16] = wdata[7:0];
                    2'b11: merge_data[31:24] = wdata[7:0];
                    default: merge_data = rd_word;
                endcase
            end
            SZ_HALF: begin
                if (lane[1]) merge_data[31:16] = wdata;
                else         merge_data[15:0]  = wdata;
            end
            default: merge_data = rd_word;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one request at a time to a word memory, sub-word stores by RMW.
// Latency: word store 1, load 2, sub-word store 3, trap 0 cycles from accept to Rsp_valid.
// Backpressure: Req_ready only in IDLE; trap on misalignment only with LSU_MISALIGN_TRAP_EN.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req_valid,
    output logic              Req_ready,
    input  logic              Req_we,
    input  logic [1:0]        Req_size,
    input  logic              Req_unsigned,
    input  logic [ADDR_W-1:0] Req_addr,
    input  logic [DATA_W-1:0] Req_wdata,
    output logic              Rsp_valid,
    output logic [DATA_W-1:0] Rsp_rdata,
    output logic              Misaligned,
    output logic [ADDR_W-1:0] Mem_address,
    output logic [DATA_W-1:0] Mem_data_in,
    output logic              Mem_we,
    output logic              Mem_re,
    input  logic [DATA_W-1:0] Mem_data_out
);

    state_t state_q, state_d;

    logic [1:0]        size_q, size_d;
    logic [1:0]        lane_q, lane_d;
    logic              uns_q, uns_d;
    logic [15:0]       wdata_q, wdata_d;

    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_re_q, mem_re_d;

    logic [1:0]        acc_size;
    logic [1:0]        acc_lane;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] merge_data;

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned_q, misaligned_d;
    logic acc_illegal;
`endif

    // Request size/lane as they will be executed; without trapping, the low
    // address bits are forced to natural alignment and size 11 becomes a word.
    always_comb begin
        acc_size = Req_size;
        acc_lane = Req_addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
        acc_illegal = access_illegal(Req_size, Req_addr[1:0]);
`else
        if (Req_size == SZ_RSVD) acc_size = SZ_WORD;
        if (acc_size == SZ_HALF)      acc_lane[0] = 1'b0;
        else if (acc_size == SZ_WORD) acc_lane    = 2'b00;
`endif
    end

    lsu_lane_align u_align (
        .rd_word    (Mem_data_out),
        .lane       (lane_q),
        .size       (size_q),
        .uns        (uns_q),
        .wdata      (wdata_q),
        .ld_data    (ld_data),
        .merge_data (merge_data)
    );

    always_comb begin
        state_d       = state_q;
        size_d        = size_q;
        lane_d        = lane_q;
        uns_d         = uns_q;
        wdata_d       = wdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = '0;
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;
        mem_we_d      = 1'b0;
        mem_re_d      = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        misaligned_d  = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (Req_valid && req_ready_q) begin
                    size_d        = acc_size;
                    lane_d        = acc_lane;
                    uns_d         = Req_unsigned;
                    wdata_d       = Req_wdata[15:0];
                    mem_address_d = {Req_addr[ADDR_W-1:2], 2'b00};
`ifdef LSU_MISALIGN_TRAP_EN
                    if (acc_illegal) begin
                        state_d      = ERR;
                        rsp_valid_d  = 1'b1;
                        misaligned_d = 1'b1;
                        mem_address_d = mem_address_q;
                    end else
`endif
                    if (!Req_we) begin
                        state_d  = LD_RD;
                        mem_re_d = 1'b1;
                    end else if (acc_size == SZ_WORD) begin
                        state_d       = ST_WR;
                        mem_we_d      = 1'b1;
                        mem_data_in_d = Req_wdata;
                    end else begin
                        state_d  = RMW_RD;
                        mem_re_d = 1'b1;
                    end
                end
            end
            LD_RD:  state_d = LD_CAP;
            LD_CAP: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = ld_data;
            end
            ST_WR: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
            end
            RMW_RD: state_d = RMW_MERGE;
            RMW_MERGE: begin
                state_d       = RMW_WR;
                mem_we_d      = 1'b1;
                mem_data_in_d = merge_data;
            end
            RMW_WR: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
            end
`ifdef LSU_MISALIGN_TRAP_EN
            ERR: state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= IDLE;
            size_q        <= SZ_BYTE;
            lane_q        <= 2'b00;
            uns_q         <= 1'b0;
            wdata_q       <= '0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
            mem_we_q      <= 1'b0;
            mem_re_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            size_q        <= size_d;
            lane_q        <= lane_d;
            uns_q         <= uns_d;
            wdata_q       <= wdata_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
            mem_we_q      <= mem_we_d;
            mem_re_q      <= mem_re_d;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge Clk) begin
        if (Reset) misaligned_q <= 1'b0;
        else       misaligned_q <= misaligned_d;
    end
    assign Misaligned = misaligned_q;
`else
    assign Misaligned = 1'b0;
`endif

    assign Req_ready   = req_ready_q;
    assign Rsp_valid   = rsp_valid_q;
    assign Rsp_rdata   = rsp_rdata_q;
    assign Mem_address = mem_address_q;
    assign Mem_data_in = mem_data_in_q;
    assign Mem_we      = mem_we_q;
    assign Mem_re      = mem_re_q;

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller between the datapath and `Data_mem`. It accepts one load or store request at a time and issues word-aligned accesses to the 32-bit word memory. Byte and halfword stores are done as read-modify-write; loads return sign- or zero-extended results. The datapath sees a valid/ready request channel and a one-cycle response pulse.

## Interface
- `ADDR_W`, 32: byte-address width
- `DATA_W`, 32: word width; only 32 is supported
- `Clk` in 1: single clock, all registers update on the rising edge
- `Reset` in 1: synchronous, active-high
- `Req_valid` in 1: request present
- `Req_ready` out 1: controller can accept a request
- `Req_we` in 1: 1 = store, 0 = load
- `Req_size` in 2: 00 byte, 01 half, 10 word, 11 reserved
- `Req_unsigned` in 1: zero-extend loads
- `Req_addr` in ADDR_W: byte address
- `Req_wdata` in DATA_W: store data, right-justified
- `Rsp_valid` out 1: one-cycle completion pulse
- `Rsp_rdata` out DATA_W: load result; 0 for stores
- `Misaligned` out 1: error flag, valid with `Rsp_valid`
- `Mem_address` out ADDR_W: word-aligned, so bits [1:0] are always 0
- `Mem_data_in` out DATA_W: write word to `Data_mem`
- `Mem_we` out 1: memory write enable
- `Mem_re` out 1: memory read enable
- `Mem_data_out` in DATA_W: read data; valid in the cycle after `Mem_re` is sampled

## Operation
- Byte order is little-endian. Lane = `addr[1:0]`; the half select is `addr[1]`.
- All outputs are registered (Moore). Reset values:
  - `Req_ready` = 1
  - all other outputs = 0
  - state = IDLE
- Handshake: a request is accepted on a rising edge where `Req_valid && Req_ready`. `Req_ready` is 1 only in IDLE. Request fields are latched at acceptance.
- States and transitions:
  - IDLE → LD_RD for a load.
  - IDLE → ST_WR for a word store.
  - IDLE → RMW_RD for a byte or halfword store.
  - IDLE → ERR for an illegal access.
  - LD_RD (`Mem_re`=1) → LD_CAP: extract and extend the lane from `Mem_data_out` into `Rsp_rdata`.
  - LD_CAP → IDLE, with `Rsp_valid` = 1.
  - ST_WR (`Mem_we`=1, `Mem_data_in` = wdata) → IDLE, with `Rsp_valid` = 1.
  - RMW_RD (`Mem_re`=1) → RMW_MERGE: replace the addressed lane(s) of `Mem_data_out` with the low byte or half of wdata.
  - RMW_MERGE → RMW_WR (`Mem_we`=1) → IDLE, with `Rsp_valid` = 1.
  - ERR → IDLE, with `Rsp_valid` = 1 and `Misaligned` = 1. No memory access is made.
- An access is illegal when a half has `addr[0]`=1, a word has `addr[1:0]`≠0, or size is 11 (only when the macro is defined).
- `Mem_we` and `Mem_re` are never high together, and each is high for exactly one cycle per access.
- The response pulse occurs in the first IDLE cycle. A new request may be accepted on the edge that ends that cycle, so back-to-back throughput is allowed.

## Timing
Acceptance edge = E0.
- Word store: `Mem_we` high E0–E1; memory writes at E1; `Rsp_valid` high E1–E2.
- Load: `Mem_re` high E0–E1; capture E1–E2; `Rsp_valid` high E2–E3.
- Sub-word store: read E0–E1, merge E1–E2, `Mem_we` high E2–E3, `Rsp_valid` high E3–E4.
- Error: `Rsp_valid` and `Misaligned` high E0–E1.
- Reset mid-operation: the state returns to IDLE after the reset edge, with no response and no further memory strobes. A write sampled by memory on the reset edge itself still completes; a pending RMW write is dropped.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- Defined: illegal accesses go to ERR as described above.
- Undefined:
  - `Misaligned` is tied to 0 and ERR is removed.
  - Size 11 is treated as word.
  - For half and word accesses, the low address bits are forced down to natural alignment and the access proceeds normally.

## Structure
- Package `lsu_pkg` holds:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`
  - the state enum
  - the width constants
- Sub-module `lsu_lane_align` (combinational) performs:
  - load lane extraction with sign or zero extension
  - store lane merge
- `lsu_ctrl` holds the FSM and all registers.

## Test plan
- Word store 0xDEADBEEF @0x10, then word load @0x10: `Mem_we` high 1 cycle; `Rsp_rdata` = 0xDEADBEEF at E2.
- Byte store 0xAB @0x11 over 0xDEADBEEF: memory word becomes 0xDEADABEF; `Rsp_valid` at E3.
- Word 0x80007F00 @0x20 loaded three ways:
  - LB @0x23 → 0xFFFFFF80
  - LBU @0x23 → 0x00000080
  - LH @0x20 → 0x00007F00
- With the macro, LH @0x21: `Misaligned` = 1 with `Rsp_valid` during E0–E1; `Mem_re`/`Mem_we` never asserted. Without the macro: the access reads @0x20 and `Misaligned` = 0.
- `Reset` asserted during RMW_MERGE: no `Mem_we`, no `Rsp_valid`, `Req_ready` = 1 next cycle, memory unchanged.
- Two loads presented back-to-back with `Req_valid` held: the second is accepted in the first load's `Rsp_valid` cycle; there are no idle cycles between responses other than the FSM latency.
